// File: rtl/food_map_pkg.sv
// Shared constants and state encoding for the pellet map controller.
package food_map_pkg;
    localparam int MAP_ROWS   = 50;
    localparam int MAP_COLS   = 80;
    localparam int TILE_SHIFT = 4;

    localparam logic [MAP_COLS-1:0] FULL_ROW = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_READ   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;
endpackage

// File: rtl/food_map_ctrl_if.sv
// Renderer / game-logic facing signals of the pellet map controller.
interface food_map_ctrl_if;
    import food_map_pkg::*;

    logic                clear_map;
    logic [5:0]          food_idx_y;
    logic [MAP_COLS-1:0] food_row;
    logic [10:0]         pacman_blkpos_x;
    logic [9:0]          pacman_blkpos_y;
    logic                pos_valid;
    logic                ready;
    logic                food_eaten;
    logic [15:0]         score;

    modport master (
        output clear_map, food_idx_y, pacman_blkpos_x, pacman_blkpos_y, pos_valid,
        input  food_row, ready, food_eaten, score
    );

    modport slave (
        input  clear_map, food_idx_y, pacman_blkpos_x, pacman_blkpos_y, pos_valid,
        output food_row, ready, food_eaten, score
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Four-digit BCD up-counter that sticks at 9999 instead of wrapping.
module bcd_score_counter (
    input  logic        clk,
    input  logic        inc,
    input  logic        clr,
    output logic [15:0] score
);
    logic [15:0] cnt_q;

    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= bcd_inc_sat(cnt_q);
        end
    end

    assign score = cnt_q;
endmodule

// File: rtl/food_map_ctrl.sv
// Pellet map owner: refills on restart, clears pellets under Pac-Man, keeps score.
module food_map_ctrl #(
    parameter int MAP_ROWS   = food_map_pkg::MAP_ROWS,
    parameter int MAP_COLS   = food_map_pkg::MAP_COLS,
    parameter int TILE_SHIFT = food_map_pkg::TILE_SHIFT
) (
    input  logic           clk,
    input  logic           rst,
    food_map_ctrl_if.slave io
);
    import food_map_pkg::*;

    localparam int RW = $clog2(MAP_ROWS);
    localparam int CW = $clog2(MAP_COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(MAP_ROWS - 1);
    localparam logic [RW-1:0] RD_LIM   = RW'(MAP_ROWS);
    localparam logic [10:0]   COL_LIM  = 11'(MAP_COLS);
    localparam logic [9:0]    ROW_LIM  = 10'(MAP_ROWS);

    logic [MAP_COLS-1:0] mem [MAP_ROWS];

    state_t              state;
    logic [RW-1:0]       row_cnt;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [MAP_COLS-1:0] buf_q;
    logic [MAP_COLS-1:0] food_row_q;
    logic                ready_q;
    logic                eaten_q;

    logic [10:0]         tile_x;
    logic [9:0]          tile_y;
    logic                accept;
    logic                abort;
    logic                hit;
    logic                mem_we;
    logic [RW-1:0]       mem_wa;
    logic [MAP_COLS-1:0] mem_wd;

    always_comb begin
        tile_x = io.pacman_blkpos_x >> TILE_SHIFT;
        tile_y = io.pacman_blkpos_y >> TILE_SHIFT;
        accept = io.pos_valid
              && (io.pacman_blkpos_x[TILE_SHIFT-1:0] == '0)
              && (io.pacman_blkpos_y[TILE_SHIFT-1:0] == '0)
              && (tile_x < COL_LIM) && (tile_y < ROW_LIM);
    end

    // Restart outranks everything, including an in-flight read-modify-write.
    assign abort = rst || io.clear_map;
    assign hit   = (state == ST_UPDATE) && buf_q[col_q];

    always_comb begin
        mem_we        = 1'b0;
        mem_wa        = row_q;
        mem_wd        = buf_q;
        mem_wd[col_q] = 1'b0;
        if (!abort) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
                mem_wa = row_cnt;
                mem_wd = FULL_ROW[MAP_COLS-1:0];
            end else if (hit) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            state   <= ST_INIT;
            row_cnt <= '0;
            ready_q <= 1'b0;
            eaten_q <= 1'b0;
        end else begin
            eaten_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (row_cnt == LAST_ROW) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        row_q   <= tile_y[RW-1:0];
                        col_q   <= tile_x[CW-1:0];
                        state   <= ST_READ;
                        ready_q <= 1'b0;
                    end
                end
                ST_READ: state <= ST_UPDATE;
                ST_UPDATE: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    eaten_q <= buf_q[col_q];
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // RMW port: write-back and buffer fetch share one address path.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (state == ST_READ) buf_q <= mem[row_q];
    end

    // Display port is read-first against the RMW write above.
    always_ff @(posedge clk) begin
        if (rst) begin
            food_row_q <= '0;
        end else if (io.food_idx_y < RD_LIM) begin
            food_row_q <= mem[io.food_idx_y];
        end else begin
            food_row_q <= '0;
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .inc   (hit && !abort),
        .clr   (abort),
        .score (io.score)
    );

    assign io.food_row   = food_row_q;
    assign io.ready      = ready_q;
    assign io.food_eaten = eaten_q;
endmodule
